issue_stage: RTL and testbench



---
 rtl/issue_stage.sv | 142 ++++++++++++++
 tb/tb_issue_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stage.sv
// Decode-to-execute issue register: holds one decoded instruction, resolves its
// rs1/rs2 operands through MEM/WB forwarding and stalls while a load result is pending.
module issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [3:0]  in_alu_op,
  input  logic        in_src1_pc,
  input  logic        in_src2_imm,
  input  logic        in_we,
  input  logic        in_is_load,
  input  logic        mem_we,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        mem_data_ok,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_op,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [31:0] out_store_data,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_is_load
);

  logic             held_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      imm_reg;
  logic [3:0]       alu_op_reg;
  logic [4:0]       rd_reg;
  logic             src1_pc_reg;
  logic             src2_imm_reg;
  logic             we_reg;
  logic             is_load_reg;
  logic [1:0][4:0]  rs_idx_reg;
  logic [1:0][31:0] rs_data_reg;

  logic [1:0][31:0] fwd;
  logic [1:0]       haz;
  logic             accept;
  logic             issue;

  // Per-operand forwarding; MEM is the younger producer so it wins over WB.
  // With nothing held the raw register is shown so outputs stay frozen.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [31:0] fwd_val;
      logic        haz_val;
      always_comb begin
        fwd_val = rs_data_reg[gi];
        haz_val = 1'b0;
        if (held_reg) begin
          if (rs_idx_reg[gi] == 5'd0) begin
            fwd_val = 32'h0;
          end else if (mem_we && (mem_rd == rs_idx_reg[gi])) begin
            fwd_val = mem_data;
            haz_val = !mem_data_ok;
          end else if (wb_we && (wb_rd == rs_idx_reg[gi])) begin
            fwd_val = wb_data;
          end
        end
      end
      assign fwd[gi] = fwd_val;
      assign haz[gi] = haz_val;
    end
  endgenerate

  assign out_valid = held_reg && (haz == 2'b00);
  assign issue     = out_valid && out_ready;
  assign in_ready  = !held_reg || issue;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg     <= 1'b0;
      pc_reg       <= '0;
      imm_reg      <= '0;
      alu_op_reg   <= '0;
      rd_reg       <= '0;
      src1_pc_reg  <= 1'b0;
      src2_imm_reg <= 1'b0;
      we_reg       <= 1'b0;
      is_load_reg  <= 1'b0;
      rs_idx_reg   <= '0;
      rs_data_reg  <= '0;
    end else if (flush) begin
      held_reg <= 1'b0;
    end else if (accept) begin
      held_reg       <= 1'b1;
      pc_reg         <= in_pc;
      imm_reg        <= in_imm;
      alu_op_reg     <= in_alu_op;
      rd_reg         <= in_rd;
      src1_pc_reg    <= in_src1_pc;
      src2_imm_reg   <= in_src2_imm;
      we_reg         <= in_we;
      is_load_reg    <= in_is_load;
      rs_idx_reg[0]  <= in_rs1;
      rs_idx_reg[1]  <= in_rs2;
      rs_data_reg[0] <= in_rs1_data;
      rs_data_reg[1] <= in_rs2_data;
    end else begin
      if (issue) begin
        held_reg <= 1'b0;
      end
      // Capture forwarded values so they outlive their producer during a stall
      // and remain visible after the instruction leaves.
      if (held_reg) begin
        for (int i = 0; i < 2; i++) begin
          if (!haz[i]) begin
            rs_data_reg[i] <= fwd[i];
          end
        end
      end
    end
  end

  assign alu_op         = alu_op_reg;
  assign src1           = src1_pc_reg ? pc_reg : fwd[0];
  assign src2           = src2_imm_reg ? imm_reg : fwd[1];
  assign out_store_data = fwd[1];
  assign out_pc         = pc_reg;
  assign out_rd         = rd_reg;
  assign out_we         = we_reg;
  assign out_is_load    = is_load_reg;

endmodule

// File: tb/tb_issue_stage.sv
// Scoreboard bench for issue_stage: directed scenarios followed by random traffic,
// checked against a "freshest producer value" operand model.
module tb_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_alu_op;
  logic        in_src1_pc, in_src2_imm, in_we, in_is_load;
  logic        mem_we, mem_data_ok, wb_we;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  alu_op;
  logic [31:0] src1, src2, out_store_data, out_pc;
  logic [4:0]  out_rd;
  logic        out_we, out_is_load;

  issue_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm), .in_we(in_we), .in_is_load(in_is_load),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data), .mem_data_ok(mem_data_ok),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .src1(src1), .src2(src2),
    .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd), .out_we(out_we),
    .out_is_load(out_is_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush, in_valid, out_ready;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        s1pc, s2imm, we, ld;
    logic        mwe, mok, wwe;
    logic [4:0]  mrd, wrd;
    logic [31:0] mdata, wdata;
  } stim_t;

  // An instruction in flight, with the operand values it currently believes in.
  typedef struct {
    logic [31:0] pc, imm, v1, v2;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        s1pc, s2imm, we, ld;
  } instr_t;

  instr_t exp_q[$];
  int     total = 0;
  int     bad = 0;
  bit     mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.out_ready = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    flush = s.flush; in_valid = s.in_valid; out_ready = s.out_ready;
    in_pc = s.pc; in_imm = s.imm; in_rs1_data = s.d1; in_rs2_data = s.d2;
    in_rs1 = s.rs1; in_rs2 = s.rs2; in_rd = s.rd; in_alu_op = s.op;
    in_src1_pc = s.s1pc; in_src2_imm = s.s2imm; in_we = s.we; in_is_load = s.ld;
    mem_we = s.mwe; mem_rd = s.mrd; mem_data = s.mdata; mem_data_ok = s.mok;
    wb_we = s.wwe; wb_rd = s.wrd; wb_data = s.wdata;
  endtask

  // One cycle of stimulus; whatever the stage takes in is pushed to the scoreboard.
  task automatic tick(input stim_t s);
    instr_t t;
    @(posedge clk);
    #1 apply(s);
    #6;
    if (s.in_valid && in_ready && !s.flush) begin
      t.pc = s.pc; t.imm = s.imm; t.v1 = s.d1; t.v2 = s.d2;
      t.rs1 = s.rs1; t.rs2 = s.rs2; t.rd = s.rd; t.op = s.op;
      t.s1pc = s.s1pc; t.s2imm = s.s2imm; t.we = s.we; t.ld = s.ld;
      exp_q.push_back(t);
    end
  endtask

  // Architectural view: an operand takes the newest value any producer offers;
  // a MEM producer whose data is not ready blocks the instruction.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] cur,
                                         output logic wait_mem);
    wait_mem = 1'b0;
    if (r == 5'd0) return 32'h0;
    if (mem_we && mem_rd == r) begin
      if (!mem_data_ok) begin
        wait_mem = 1'b1;
        return cur;
      end
      return mem_data;
    end
    if (wb_we && wb_rd == r) return wb_data;
    return cur;
  endfunction

  initial begin : monitor
    instr_t h;
    logic [31:0] f1, f2;
    logic w1, w2, exp_valid, exp_issue;
    forever begin
      @(posedge clk);
      #4;
      if (mon_en) begin
        exp_valid = 1'b0;
        if (exp_q.size() > 0) begin
          h = exp_q[0];
          f1 = newest(h.rs1, h.v1, w1);
          f2 = newest(h.rs2, h.v2, w2);
          exp_valid = !(w1 || w2);
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
        exp_issue = exp_valid && out_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || exp_issue});
        if (exp_valid) begin
          chk("src1", src1, h.s1pc ? h.pc : f1);
          chk("src2", src2, h.s2imm ? h.imm : f2);
          chk("store_data", out_store_data, f2);
          chk("out_pc", out_pc, h.pc);
          chk("alu_op", {28'b0, alu_op}, {28'b0, h.op});
          chk("out_rd", {27'b0, out_rd}, {27'b0, h.rd});
          chk("out_we_ld", {30'b0, out_we, out_is_load}, {30'b0, h.we, h.ld});
        end
        if (exp_q.size() > 0) begin
          if (exp_issue) begin
            $display("issue pc=%h op=%0d src1=%h src2=%h store=%h rd=%0d",
                     out_pc, alu_op, src1, src2, out_store_data, out_rd);
            void'(exp_q.pop_front());
          end else begin
            exp_q[0].v1 = f1;
            exp_q[0].v2 = f2;
          end
        end
        if (flush) exp_q.delete();
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'h1);
    chk({tag, "_src1"}, src1, 32'h0);
    chk({tag, "_src2"}, src2, 32'h0);
    chk({tag, "_store"}, out_store_data, 32'h0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_side"}, {23'b0, alu_op, out_rd, out_we, out_is_load}, 32'h0);
  endtask

  initial begin
    stim_t s;
    rst_n = 1'b0;
    apply(idle());
    #12;
    chk_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Back-to-back independent stream.
    for (int i = 0; i < 4; i++) begin
      s = idle();
      s.in_valid = 1'b1; s.pc = 32'h100 + 32'(4 * i); s.rs1 = 5'(i + 1);
      s.d1 = 32'(5 + i); s.imm = 32'(7 + i); s.s2imm = 1'b1; s.op = 4'(i); s.rd = 5'(10 + i);
      tick(s);
    end
    tick(idle());

    // Forwarding priority: MEM over WB, then WB alone, then x0.
    s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd3; s.d1 = 32'h1; s.pc = 32'h200;
    tick(s);
    s = idle(); s.out_ready = 1'b0;
    s.mwe = 1'b1; s.mrd = 5'd3; s.mdata = 32'hAA; s.mok = 1'b1;
    s.wwe = 1'b1; s.wrd = 5'd3; s.wdata = 32'hBB;
    tick(s);
    s.mwe = 1'b0; s.out_ready = 1'b1;
    tick(s);
    s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd0; s.d1 = 32'h77; s.pc = 32'h204;
    tick(s);
    s = idle(); s.mwe = 1'b1; s.mrd = 5'd0; s.mdata = 32'hAA; s.mok = 1'b1;
    s.wwe = 1'b1; s.wrd = 5'd0; s.wdata = 32'hBB;
    tick(s);

    // Load-use: two cycles of pending MEM data on rs2.
    s = idle(); s.in_valid = 1'b1; s.rs2 = 5'd5; s.d2 = 32'h9; s.pc = 32'h300;
    tick(s);
    s = idle(); s.mwe = 1'b1; s.mrd = 5'd5; s.mdata = 32'hDEAD; s.mok = 1'b0;
    tick(s);
    tick(s);
    s.mok = 1'b1; s.mdata = 32'h1234;
    tick(s);
    tick(idle());

    // Stall refresh: WB value must survive after WB moves on.
    s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd7; s.d1 = 32'h0; s.pc = 32'h400;
    tick(s);
    s = idle(); s.out_ready = 1'b0; s.wwe = 1'b1; s.wrd = 5'd7; s.wdata = 32'h55;
    tick(s);
    s.wwe = 1'b0;
    tick(s);
    tick(idle());

    // Flush kills both the held and the incoming instruction.
    s = idle(); s.in_valid = 1'b1; s.out_ready = 1'b0; s.pc = 32'h500; s.rs1 = 5'd2;
    tick(s);
    s.pc = 32'h504; s.flush = 1'b1;
    tick(s);
    tick(idle());
    tick(idle());

    // Random traffic with a small register range so producers often match.
    for (int c = 0; c < 600; c++) begin
      s.flush = ($urandom_range(0, 15) == 0);
      s.in_valid = ($urandom_range(0, 3) != 0);
      s.out_ready = ($urandom_range(0, 3) != 0);
      s.pc = $urandom; s.imm = $urandom; s.d1 = $urandom; s.d2 = $urandom;
      s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 31)); s.op = 4'($urandom_range(0, 15));
      s.s1pc = 1'($urandom); s.s2imm = 1'($urandom); s.we = 1'($urandom); s.ld = 1'($urandom);
      s.mwe = 1'($urandom); s.mok = ($urandom_range(0, 3) != 0);
      s.mrd = 5'($urandom_range(0, 7)); s.mdata = $urandom;
      s.wwe = 1'($urandom); s.wrd = 5'($urandom_range(0, 7)); s.wdata = $urandom;
      tick(s);
    end
    tick(idle());

    // Asynchronous reset while stalled on backpressure.
    s = idle(); s.in_valid = 1'b1; s.out_ready = 1'b0; s.pc = 32'h600; s.s1pc = 1'b1;
    s.imm = 32'h33; s.s2imm = 1'b1; s.rs2 = 5'd4; s.d2 = 32'h44; s.op = 4'd9; s.rd = 5'd6;
    s.we = 1'b1; s.ld = 1'b1;
    tick(s);
    s = idle(); s.out_ready = 1'b0;
    tick(s);
    #1 rst_n = 1'b0;
    mon_en = 1'b0;
    #1 chk_zero_outputs("async_rst");
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    s = idle(); s.in_valid = 1'b1; s.pc = 32'h700; s.rs1 = 5'd1; s.d1 = 32'h11;
    tick(s);
    tick(idle());
    tick(idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
